// File: rtl/mat_pkg.sv
// Shared constants and symbol record for the coefficient-block datapath.
// Also holds the sign-extension helper used by the encoder.
package mat_pkg;

   localparam int DW = 10;
   localparam int N  = 64;
   localparam int RW = 6;

   typedef struct packed {
      logic [RW-1:0] run;
      logic [3:0]    size;
      logic [DW:0]   amp;
      logic          is_dc;
      logic          eob;
      logic          last;
   } sym_t;

   localparam sym_t SYM_ZERO = '0;

   function automatic logic signed [DW:0] sext(input logic signed [DW-1:0] v);
      return {v[DW-1], v};
   endfunction

endpackage

// File: rtl/mat_rle_if.sv
// Coefficient-in / symbol-out bundle between mat_scan, mat_rle and the Huffman stage.
interface mat_rle_if;
   import mat_pkg::*;

   logic                 vld_in;
   logic signed [DW-1:0] din;
   logic                 dc_clr;

   logic                 vld_out;
   logic [RW-1:0]        run;
   logic [3:0]           size;
   logic [DW:0]          amp;
   logic                 is_dc;
   logic                 eob;
   logic                 last;

   modport master (
      output vld_in, din, dc_clr,
      input  vld_out, run, size, amp, is_dc, eob, last
   );

   modport slave (
      input  vld_in, din, dc_clr,
      output vld_out, run, size, amp, is_dc, eob, last
   );

endinterface

// File: rtl/mat_rle_size.sv
// Magnitude category and amplitude bits of a signed value; negative values
// are coded one's-complement in the low `size` bits, upper bits forced to zero.
module mat_rle_size
   import mat_pkg::*;
(
   input  logic signed [DW:0] i_val,
   output logic [3:0]         o_size,
   output logic [DW:0]        o_amp
);

   logic [DW:0] w_mag;
   logic [DW:0] w_mask;
   logic [DW:0] w_ones;

   always_comb begin
      w_mag  = i_val[DW] ? $unsigned(-i_val) : $unsigned(i_val);
      o_size = '0;
      // Highest set bit wins, so the loop runs low to high.
      for (int i = 0; i <= DW; i++) begin
         if (w_mag[i]) o_size = 4'(i + 1);
      end
      w_mask = ({{DW{1'b0}}, 1'b1} << o_size) - {{DW{1'b0}}, 1'b1};
      w_ones = $unsigned(i_val) - {{DW{1'b0}}, 1'b1};
      o_amp  = (i_val[DW] ? w_ones : $unsigned(i_val)) & w_mask;
   end

endmodule

// File: rtl/mat_rle.sv
// Run-length / category encoder for one zigzag-ordered 8x8 block: DC as DPCM
// difference, AC as (zero-run, size, amplitude), EOB when the block ends in zeros.
module mat_rle
   import mat_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   mat_rle_if.slave bus
);

   logic [RW-1:0]        r_pos;
   logic [RW-1:0]        r_zrun;
   logic signed [DW-1:0] r_pred;

   logic                 w_at_dc;
   logic                 w_at_last;
   logic                 w_nz;
   logic                 w_emit_p0;
   logic signed [DW-1:0] w_pred_eff;
   logic signed [DW:0]   w_val_p0;
   logic [RW-1:0]        w_run_p0;
   logic                 w_eob_p0;

   logic                 r_vld_p1;
   logic signed [DW:0]   r_val_p1;
   logic [RW-1:0]        r_run_p1;
   logic                 r_dc_p1;
   logic                 r_eob_p1;
   logic                 r_last_p1;

   logic [3:0]           w_size_p1;
   logic [DW:0]          w_amp_p1;
   sym_t                 w_sym_p1;

   logic                 r_vld_p2;
   sym_t                 r_sym_p2;

   // Stage 0: classify the incoming coefficient against block position.
   always_comb begin
      w_at_dc    = (r_pos == '0);
      w_at_last  = (r_pos == RW'(N - 1));
      w_nz       = (bus.din != '0);
      w_pred_eff = bus.dc_clr ? '0 : r_pred;
      w_emit_p0  = bus.vld_in && (w_at_dc || w_nz || w_at_last);
      w_eob_p0   = !w_at_dc && !w_nz && w_at_last;
      w_run_p0   = (w_at_dc || !w_nz) ? '0 : r_zrun;
      if (w_at_dc)
         w_val_p0 = sext(bus.din) - sext(w_pred_eff);
      else if (w_nz)
         w_val_p0 = sext(bus.din);
      else
         w_val_p0 = '0;
   end

   always_ff @(posedge clk) begin
      r_val_p1  <= w_val_p0;
      r_run_p1  <= w_run_p0;
      r_dc_p1   <= w_at_dc;
      r_eob_p1  <= w_eob_p0;
      r_last_p1 <= w_at_last;
   end

   // Stage 1: category and amplitude of the registered value.
   mat_rle_size u_size (
      .i_val  (r_val_p1),
      .o_size (w_size_p1),
      .o_amp  (w_amp_p1)
   );

   always_comb begin
      w_sym_p1       = SYM_ZERO;
      w_sym_p1.run   = r_run_p1;
      w_sym_p1.size  = w_size_p1;
      w_sym_p1.amp   = w_amp_p1;
      w_sym_p1.is_dc = r_dc_p1;
      w_sym_p1.eob   = r_eob_p1;
      w_sym_p1.last  = r_last_p1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos    <= '0;
         r_zrun   <= '0;
         r_pred   <= '0;
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
         r_sym_p2 <= SYM_ZERO;
      end else begin
         r_vld_p1 <= w_emit_p0;
         r_vld_p2 <= r_vld_p1;
         // Idle cycles present an all-zero symbol rather than stale fields.
         r_sym_p2 <= r_vld_p1 ? w_sym_p1 : SYM_ZERO;
         if (bus.vld_in) begin
            r_pos <= r_pos + 1'b1;
            if (w_at_dc || w_nz || w_at_last)
               r_zrun <= '0;
            else
               r_zrun <= r_zrun + 1'b1;
         end
         if (bus.vld_in && w_at_dc)
            r_pred <= bus.din;
         else if (bus.dc_clr)
            r_pred <= '0;
      end
   end

   // Stage 2: registered symbol outputs.
   assign bus.vld_out = r_vld_p2;
   assign bus.run     = r_sym_p2.run;
   assign bus.size    = r_sym_p2.size;
   assign bus.amp     = r_sym_p2.amp;
   assign bus.is_dc   = r_sym_p2.is_dc;
   assign bus.eob     = r_sym_p2.eob;
   assign bus.last    = r_sym_p2.last;

endmodule

// File: tb/tb_mat_rle.sv
// Scoreboard bench for mat_rle: directed blocks plus random gapped blocks,
// expectations from a per-block behavioural model of the symbol rules.
module tb_mat_rle;
   import mat_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mat_rle_if bus();

   mat_rle dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int run;
      int size;
      int amp;
      bit dc;
      bit eob;
      bit last;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   idx = 0;
   int   pred = 0;
   int   blk[N];

   always @(posedge clk) cyc++;

   function automatic int sz_of(input int v);
      int m;
      int s;
      m = (v < 0) ? -v : v;
      s = 0;
      while (m > 0) begin
         m = m >> 1;
         s++;
      end
      return s;
   endfunction

   function automatic int amp_of(input int v);
      int s;
      s = sz_of(v);
      if (s == 0) return 0;
      if (v >= 0) return v;
      return (v - 1) & ((1 << s) - 1);
   endfunction

   function automatic void push(input int r, input int val, input bit dc, input bit eob, input bit last);
      exp_t e;
      e.run  = r;
      e.size = sz_of(val);
      e.amp  = amp_of(val);
      e.dc   = dc;
      e.eob  = eob;
      e.last = last;
      e.cyc  = cyc + 2;
      q.push_back(e);
   endfunction

   task automatic drive(input bit v, input int d, input bit clr);
      int r;
      @(posedge clk);
      #1;
      bus.vld_in = v;
      bus.din    = DW'(d);
      bus.dc_clr = clr;
      if (clr) pred = 0;
      if (v) begin
         blk[idx] = d;
         if (idx == 0) begin
            push(0, d - pred, 1'b1, 1'b0, 1'b0);
            pred = d;
         end else if (d != 0) begin
            r = 0;
            for (int j = idx - 1; j >= 1 && blk[j] == 0; j--) r++;
            push(r, d, 1'b0, 1'b0, idx == N - 1);
         end else if (idx == N - 1) begin
            push(0, 0, 1'b0, 1'b1, 1'b1);
         end
         idx = (idx + 1) % N;
      end
   endtask

   task automatic send_block(input int vals[N], input int gap_pct, input bit clr);
      for (int i = 0; i < N; i++) begin
         while (int'($urandom_range(99)) < gap_pct)
            drive(1'b0, int'($urandom_range(1023)) - 512, $urandom_range(15) == 0);
         drive(1'b1, vals[i], (i == 0) ? clr : 1'b0);
      end
   endtask

   task automatic do_reset(input int hold);
      logic [RW+4+DW+1+4-1:0] outs;
      @(posedge clk);
      #1;
      rst_n      = 1'b0;
      bus.vld_in = 1'b0;
      bus.din    = '0;
      bus.dc_clr = 1'b0;
      q.delete();
      idx  = 0;
      pred = 0;
      @(negedge clk);
      outs = {bus.vld_out, bus.run, bus.size, bus.amp, bus.is_dc, bus.eob, bus.last};
      checks++;
      if (outs != '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", outs);
      end
      repeat (hold) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: any expectation whose cycle has passed is a missing symbol.
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         checks++;
         failures++;
         $display("FAIL missing_symbol got=none want run=%0d size=%0d amp=%0h dc=%0b eob=%0b last=%0b at cycle %0d",
                  e.run, e.size, e.amp, e.dc, e.eob, e.last, e.cyc);
      end
      if (rst_n && bus.vld_out) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_symbol got run=%0d size=%0d amp=%0h dc=%0b eob=%0b last=%0b at cycle %0d want=none",
                     bus.run, bus.size, bus.amp, bus.is_dc, bus.eob, bus.last, cyc);
         end else begin
            e = q.pop_front();
            if (int'(bus.run) != e.run || int'(bus.size) != e.size || int'(bus.amp) != e.amp ||
                bus.is_dc != e.dc || bus.eob != e.eob || bus.last != e.last || cyc != e.cyc) begin
               failures++;
               $display("FAIL symbol got run=%0d size=%0d amp=%0h dc=%0b eob=%0b last=%0b cyc=%0d want run=%0d size=%0d amp=%0h dc=%0b eob=%0b last=%0b cyc=%0d",
                        bus.run, bus.size, bus.amp, bus.is_dc, bus.eob, bus.last, cyc,
                        e.run, e.size, e.amp, e.dc, e.eob, e.last, e.cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int b[N];
      bus.vld_in = 1'b0;
      bus.din    = '0;
      bus.dc_clr = 1'b0;
      do_reset(3);

      b = '{default: 0};
      b[0] = 5;
      send_block(b, 0, 1'b0);
      b[0] = -3;
      b[3] = -1;
      send_block(b, 0, 1'b0);

      b = '{default: 0};
      b[0] = 40;
      b[21] = 7;
      b[22] = -512;
      send_block(b, 0, 1'b0);

      b = '{default: 0};
      b[0] = -7;
      b[63] = 1;
      send_block(b, 0, 1'b0);

      b = '{default: 0};
      b[0] = 511;
      b[5] = -512;
      b[6] = 511;
      send_block(b, 0, 1'b0);
      b[0] = -512;
      send_block(b, 0, 1'b0);
      b[0] = 511;
      send_block(b, 0, 1'b0);

      b = '{default: 0};
      b[0] = 100;
      send_block(b, 0, 1'b0);
      b[0] = 9;
      send_block(b, 0, 1'b1);

      // Partial block interrupted by reset at position 30.
      for (int i = 0; i < 30; i++) drive(1'b1, (i % 3 == 0) ? i + 1 : 0, 1'b0);
      do_reset(2);
      b = '{default: 0};
      b[0] = 77;
      b[10] = -20;
      send_block(b, 0, 1'b0);

      repeat (40) begin
         for (int i = 0; i < N; i++)
            b[i] = ($urandom_range(3) == 0) ? int'($urandom_range(1023)) - 512 : 0;
         b[0] = int'($urandom_range(1023)) - 512;
         send_block(b, 30, $urandom_range(7) == 0);
      end

      repeat (3) drive(1'b0, 0, 1'b0);
      for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d pending want=0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
